ct_mmu_jtlb_data_ctrl: RTL and testbench

Access controller directly upstream of the JTLB data array: arbitrates lookup reads against refill writes, drives the array's chip-enable/way-write-enable/index/data pins, and consumes the two 84-bit bank outputs. It selects the hit way's 42-bit entry and returns it two cycles after request acceptance. Refill writes pass through a one-entry write buffer, and an anti-starvation counter guarantees forward progress for the buffered write.

---
 rtl/ct_mmu_jtlb_data_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ct_mmu_jtlb_data_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_mmu_jtlb_data_ctrl.sv
// JTLB data-array access controller: arbitrates lookup reads against buffered refill
// writes, drives the array pins and returns the hit-way entry two cycles after acceptance.
`timescale 1ns/1ps
module ct_mmu_jtlb_data_ctrl #(
  parameter int IDX_W      = 8,
  parameter int WAY_W      = 42,
  parameter int STARVE_MAX = 4
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst_b,
  input  logic               lkup_req_vld,
  input  logic [IDX_W-1:0]   lkup_req_idx,
  output logic               lkup_req_rdy,
  input  logic [3:0]         tag_hit_way,
  output logic               lkup_rsp_vld,
  output logic               lkup_rsp_hit,
  output logic               lkup_rsp_multi,
  output logic [WAY_W-1:0]   lkup_rsp_data,
  input  logic               wr_req_vld,
  input  logic [IDX_W-1:0]   wr_req_idx,
  input  logic [3:0]         wr_req_way,
  input  logic [WAY_W-1:0]   wr_req_data,
  output logic               wr_req_rdy,
  output logic               jtlb_data_cen0,
  output logic               jtlb_data_cen1,
  output logic [3:0]         jtlb_data_wen,
  output logic [IDX_W-1:0]   jtlb_data_idx,
  output logic [2*WAY_W-1:0] jtlb_data_din,
  input  logic [2*WAY_W-1:0] jtlb_data_dout0,
  input  logic [2*WAY_W-1:0] jtlb_data_dout1
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX - 1);

  logic               wbuf_vld_q,   wbuf_vld_d;
  logic [IDX_W-1:0]   wbuf_idx_q,   wbuf_idx_d;
  logic [3:0]         wbuf_way_q,   wbuf_way_d;
  logic [WAY_W-1:0]   wbuf_data_q,  wbuf_data_d;
  logic [3:0]         starve_cnt_q, starve_cnt_d;
  logic               s1_vld_q,     s1_vld_d;
  logic               rsp_vld_q,    rsp_vld_d;
  logic               rsp_hit_q,    rsp_hit_d;
  logic               rsp_multi_q,  rsp_multi_d;
  logic [WAY_W-1:0]   rsp_data_q,   rsp_data_d;

  logic               force_wr;
  logic               rd_issue;
  logic               wb_issue;
  logic               wr_accept;

  // The buffered write wins only once reads have starved it for STARVE_MAX-1 grants.
  always_comb begin
    force_wr  = wbuf_vld_q && (starve_cnt_q == STARVE_LIM);
    rd_issue  = lkup_req_vld && !force_wr;
    wb_issue  = wbuf_vld_q && !rd_issue;
    wr_accept = wr_req_vld && (!wbuf_vld_q || wb_issue);
  end

  assign lkup_req_rdy = !force_wr;
  assign wr_req_rdy   = !wbuf_vld_q || wb_issue;

  always_comb begin
    wbuf_vld_d  = wbuf_vld_q;
    wbuf_idx_d  = wbuf_idx_q;
    wbuf_way_d  = wbuf_way_q;
    wbuf_data_d = wbuf_data_q;
    if (wr_accept) begin
      wbuf_vld_d  = 1'b1;
      wbuf_idx_d  = wr_req_idx;
      wbuf_way_d  = wr_req_way;
      wbuf_data_d = wr_req_data;
    end else if (wb_issue) begin
      wbuf_vld_d  = 1'b0;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!wbuf_vld_q || wb_issue) begin
      starve_cnt_d = 4'd0;
    end else if (rd_issue && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_comb begin
    jtlb_data_cen0 = 1'b0;
    jtlb_data_cen1 = 1'b0;
    jtlb_data_wen  = 4'b0000;
    jtlb_data_idx  = '0;
    jtlb_data_din  = '0;
    if (rd_issue) begin
      jtlb_data_cen0 = 1'b1;
      jtlb_data_cen1 = 1'b1;
      jtlb_data_idx  = lkup_req_idx;
    end else if (wb_issue) begin
      jtlb_data_cen0 = |wbuf_way_q[1:0];
      jtlb_data_cen1 = |wbuf_way_q[3:2];
      jtlb_data_wen  = wbuf_way_q;
      jtlb_data_idx  = wbuf_idx_q;
      jtlb_data_din  = {wbuf_data_q, wbuf_data_q};
    end
  end

  // Stage 1: array data and tag hits arrive together; mask each way by its hit bit.
  logic [WAY_W-1:0] way_entry  [4];
  logic [WAY_W-1:0] way_masked [4];
  logic [WAY_W-1:0] sel_data;
  logic             sel_hit;
  logic             sel_multi;

  assign way_entry[0] = jtlb_data_dout0[WAY_W-1:0];
  assign way_entry[1] = jtlb_data_dout0[2*WAY_W-1:WAY_W];
  assign way_entry[2] = jtlb_data_dout1[WAY_W-1:0];
  assign way_entry[3] = jtlb_data_dout1[2*WAY_W-1:WAY_W];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_way_mask
      assign way_masked[gi] = way_entry[gi] & {WAY_W{tag_hit_way[gi]}};
    end
  endgenerate

  assign sel_data  = way_masked[0] | way_masked[1] | way_masked[2] | way_masked[3];
  assign sel_hit   = |tag_hit_way;
  assign sel_multi = |(tag_hit_way & (tag_hit_way - 4'd1));

  always_comb begin
    s1_vld_d    = rd_issue;
    rsp_vld_d   = s1_vld_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_multi_d = rsp_multi_q;
    rsp_data_d  = rsp_data_q;
    if (s1_vld_q) begin
      rsp_hit_d   = sel_hit;
      rsp_multi_d = sel_multi;
      rsp_data_d  = sel_data;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wbuf_vld_q   <= 1'b0;
      wbuf_idx_q   <= '0;
      wbuf_way_q   <= 4'b0000;
      wbuf_data_q  <= '0;
      starve_cnt_q <= 4'd0;
      s1_vld_q     <= 1'b0;
      rsp_vld_q    <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_multi_q  <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      wbuf_vld_q   <= wbuf_vld_d;
      wbuf_idx_q   <= wbuf_idx_d;
      wbuf_way_q   <= wbuf_way_d;
      wbuf_data_q  <= wbuf_data_d;
      starve_cnt_q <= starve_cnt_d;
      s1_vld_q     <= s1_vld_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_multi_q  <= rsp_multi_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign lkup_rsp_vld   = rsp_vld_q;
  assign lkup_rsp_hit   = rsp_hit_q;
  assign lkup_rsp_multi = rsp_multi_q;
  assign lkup_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ct_mmu_jtlb_data_ctrl.sv
// Scoreboard bench for ct_mmu_jtlb_data_ctrl with a behavioural two-bank data array.
`timescale 1ns/1ps
module tb_ct_mmu_jtlb_data_ctrl;
  localparam int IDX_W = 8;
  localparam int WAY_W = 42;
  localparam int STARVE_MAX = 4;

  logic               clk = 1'b0;
  logic               rst_b;
  logic               lkup_req_vld;
  logic [IDX_W-1:0]   lkup_req_idx;
  logic               lkup_req_rdy;
  logic [3:0]         tag_hit_way;
  logic               lkup_rsp_vld;
  logic               lkup_rsp_hit;
  logic               lkup_rsp_multi;
  logic [WAY_W-1:0]   lkup_rsp_data;
  logic               wr_req_vld;
  logic [IDX_W-1:0]   wr_req_idx;
  logic [3:0]         wr_req_way;
  logic [WAY_W-1:0]   wr_req_data;
  logic               wr_req_rdy;
  logic               cen0;
  logic               cen1;
  logic [3:0]         wen;
  logic [IDX_W-1:0]   aidx;
  logic [2*WAY_W-1:0] din;
  logic [2*WAY_W-1:0] dout0;
  logic [2*WAY_W-1:0] dout1;

  always #5 clk = ~clk;

  ct_mmu_jtlb_data_ctrl #(
    .IDX_W(IDX_W), .WAY_W(WAY_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .forever_cpuclk  (clk),
    .cpurst_b        (rst_b),
    .lkup_req_vld    (lkup_req_vld),
    .lkup_req_idx    (lkup_req_idx),
    .lkup_req_rdy    (lkup_req_rdy),
    .tag_hit_way     (tag_hit_way),
    .lkup_rsp_vld    (lkup_rsp_vld),
    .lkup_rsp_hit    (lkup_rsp_hit),
    .lkup_rsp_multi  (lkup_rsp_multi),
    .lkup_rsp_data   (lkup_rsp_data),
    .wr_req_vld      (wr_req_vld),
    .wr_req_idx      (wr_req_idx),
    .wr_req_way      (wr_req_way),
    .wr_req_data     (wr_req_data),
    .wr_req_rdy      (wr_req_rdy),
    .jtlb_data_cen0  (cen0),
    .jtlb_data_cen1  (cen1),
    .jtlb_data_wen   (wen),
    .jtlb_data_idx   (aidx),
    .jtlb_data_din   (din),
    .jtlb_data_dout0 (dout0),
    .jtlb_data_dout1 (dout1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WAY_W-1:0] init_entry(input int i, input int w);
    logic [31:0] lo;
    lo = (32'(i) * 32'h0101_0107) ^ (32'(w) * 32'h3C3C_0001) ^ 32'h5A5A_A5A5;
    return {8'(i), 2'(w), lo};
  endfunction

  // Behavioural data array: one-cycle registered read, per-way write enable.
  logic                mem_init;
  logic [WAY_W-1:0]    arr_mem [256][4];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++)
        for (int w = 0; w < 4; w++)
          arr_mem[i][w] <= init_entry(i, w);
    end else begin
      if (cen0 && wen == 4'b0000) dout0 <= {arr_mem[aidx][1], arr_mem[aidx][0]};
      if (cen1 && wen == 4'b0000) dout1 <= {arr_mem[aidx][3], arr_mem[aidx][2]};
      for (int w = 0; w < 4; w++)
        if (wen[w] && ((w < 2) ? cen0 : cen1))
          arr_mem[aidx][w] <= (w % 2 == 1) ? din[2*WAY_W-1:WAY_W] : din[WAY_W-1:0];
    end
  end

  always @(negedge clk)
    if (rst_b && wr_req_vld)
      assert ($onehot(wr_req_way)) else $error("wr_req_way not one-hot: %b", wr_req_way);

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               cyc;
    logic             hit;
    logic             multi;
    logic [WAY_W-1:0] data;
  } exp_t;
  exp_t sb[$];
  logic [WAY_W-1:0] ref_mem [256][4];
  logic [WAY_W-1:0] last_rsp_data = '0;

  always @(negedge clk) begin
    if (rst_b && lkup_rsp_vld) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_hit",   lkup_rsp_hit,   e.hit);
        chk("rsp_multi", lkup_rsp_multi, e.multi);
        chk("rsp_data",  lkup_rsp_data,  e.data);
        last_rsp_data = e.data;
        $display("rsp cyc=%0d hit=%0b multi=%0b data=%h", cyc, lkup_rsp_hit, lkup_rsp_multi, lkup_rsp_data);
      end
    end
  end

  function automatic logic [WAY_W-1:0] exp_sel(input logic [7:0] idx, input logic [3:0] hit);
    logic [WAY_W-1:0] r;
    r = '0;
    for (int w = 0; w < 4; w++) if (hit[w]) r = r | ref_mem[idx][w];
    return r;
  endfunction

  logic             s_rdy_r, s_rdy_w, s_cen0, s_cen1, s_rsp_vld;
  logic [3:0]       s_wen;
  logic [2*WAY_W-1:0] s_din;

  // One clock of stimulus; DUT outputs are sampled on the falling edge.
  task automatic step(input logic rv, input logic [7:0] ridx, input logic [3:0] rhit,
                      input logic wv, input logic [7:0] widx, input logic [3:0] wway,
                      input logic [WAY_W-1:0] wdata);
    logic acc_r;
    exp_t e;
    lkup_req_vld = rv;  lkup_req_idx = ridx;
    wr_req_vld   = wv;  wr_req_idx   = widx;
    wr_req_way   = wway; wr_req_data = wdata;
    @(negedge clk);
    s_rdy_r = lkup_req_rdy; s_rdy_w = wr_req_rdy;
    s_cen0 = cen0; s_cen1 = cen1; s_wen = wen; s_din = din; s_rsp_vld = lkup_rsp_vld;
    acc_r = rv && lkup_req_rdy;
    if (acc_r) begin
      e.cyc = cyc + 2; e.hit = |rhit; e.multi = ($countones(rhit) > 1);
      e.data = exp_sel(ridx, rhit);
      sb.push_back(e);
      $display("rd  cyc=%0d idx=%h hit=%b", cyc, ridx, rhit);
    end
    if (wv && wr_req_rdy) begin
      for (int w = 0; w < 4; w++) if (wway[w]) ref_mem[widx][w] = wdata;
      $display("wr  cyc=%0d idx=%h way=%b data=%h", cyc, widx, wway, wdata);
    end
    @(posedge clk); #1;
    tag_hit_way  = acc_r ? rhit : 4'($urandom);
    lkup_req_vld = 1'b0;
    wr_req_vld   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h0, 4'h0, 0, 8'h0, 4'h1, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  localparam logic [WAY_W-1:0] D_T2 = 42'h2_AAAA_5555;
  localparam logic [WAY_W-1:0] D_ST = 42'h3_1234_5678;
  localparam logic [WAY_W-1:0] D_A  = 42'h1_0F0F_F0F0;
  localparam logic [WAY_W-1:0] D_B  = 42'h2_DEAD_BEEF;

  initial begin
    rst_b = 1'b0; mem_init = 1'b1;
    lkup_req_vld = 0; lkup_req_idx = 0; tag_hit_way = 0;
    wr_req_vld = 0; wr_req_idx = 0; wr_req_way = 4'h1; wr_req_data = 0;
    for (int i = 0; i < 256; i++)
      for (int w = 0; w < 4; w++) ref_mem[i][w] = init_entry(i, w);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_vld", lkup_rsp_vld, 0);
    chk("rst_rsp_hit", lkup_rsp_hit, 0);
    chk("rst_rsp_multi", lkup_rsp_multi, 0);
    chk("rst_rsp_data", lkup_rsp_data, 0);
    chk("rst_cen", {cen0, cen1, wen}, 6'b0);
    chk("rst_rdy", {lkup_req_rdy, wr_req_rdy}, 2'b11);
    @(posedge clk); #1;
    rst_b = 1'b1; mem_init = 1'b0;

    idle(1);
    chk("idle_cen", {s_cen0, s_cen1, s_wen}, 6'b0);
    chk("idle_rdy", {s_rdy_r, s_rdy_w}, 2'b11);
    chk("idle_rsp_vld", s_rsp_vld, 0);

    // Write way2 then read it back two cycles later.
    step(0, 8'h0, 4'h0, 1, 8'h15, 4'b0100, D_T2);
    chk("wr_accept", s_rdy_w, 1);
    idle(1);
    chk("wr_issue_cen", {s_cen0, s_cen1}, 2'b01);
    chk("wr_issue_wen", s_wen, 4'b0100);
    chk("wr_issue_din", s_din, {D_T2, D_T2});
    step(1, 8'h15, 4'b0100, 0, 8'h0, 4'h1, '0);
    step(1, 8'h15, 4'b0000, 0, 8'h0, 4'h1, '0);
    step(1, 8'h30, 4'b0011, 0, 8'h0, 4'h1, '0);
    for (int k = 0; k < 8; k++)
      step(1, 8'(8'hC0 + $urandom_range(0, 63)), 4'($urandom_range(0, 15)), 0, 8'h0, 4'h1, '0);
    idle(4);
    chk("rsp_hold_vld", lkup_rsp_vld, 0);
    chk("rsp_hold_data", lkup_rsp_data, last_rsp_data);

    // Starvation: write buffered at cycle 0, reads every cycle.
    for (int k = 0; k <= 10; k++) begin
      step(1, 8'(8'h80 + k), 4'($urandom_range(0, 15)), k == 0, 8'h40, 4'b0010, D_ST);
      chk($sformatf("starve_rdy_c%0d", k), s_rdy_r, (k == 4) ? 1'b0 : 1'b1);
      if (k == 4) begin
        chk("starve_wr_wen", s_wen, 4'b0010);
        chk("starve_wr_cen", {s_cen0, s_cen1}, 2'b10);
      end else begin
        chk($sformatf("starve_rd_c%0d", k), {s_cen0, s_cen1, s_wen}, 6'b110000);
      end
    end
    idle(3);

    // Second write held off until the forced issue of the first.
    for (int k = 0; k <= 6; k++) begin
      step(k <= 4, 8'(8'hA0 + k), 4'b0001, k <= 4, (k == 0) ? 8'h50 : 8'h51,
           (k == 0) ? 4'b1000 : 4'b0001, (k == 0) ? D_A : D_B);
      if (k >= 1 && k <= 4) chk($sformatf("wr2_rdy_c%0d", k), s_rdy_w, (k == 4) ? 1'b1 : 1'b0);
      if (k == 4) chk("wr2_issueA", {s_cen0, s_cen1, s_wen}, 6'b011000);
      if (k == 5) chk("wr2_issueB", {s_cen0, s_cen1, s_wen}, 6'b100001);
      if (k == 5) chk("wr2_dinB", s_din, {D_B, D_B});
    end
    step(1, 8'h50, 4'b1000, 0, 8'h0, 4'h1, '0);
    step(1, 8'h51, 4'b0001, 0, 8'h0, 4'h1, '0);
    step(1, 8'h40, 4'b0010, 0, 8'h0, 4'h1, '0);
    idle(4);

    // Reset between read accept and response.
    step(1, 8'h22, 4'b0100, 1, 8'h60, 4'b0001, 42'h1_1111_1111);
    rst_b = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_cen", {cen0, cen1, wen}, 6'b0);
    chk("midrst_rsp_vld", lkup_rsp_vld, 0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle(1);
      chk($sformatf("postrst_rsp_vld_%0d", k), s_rsp_vld, 0);
      chk($sformatf("postrst_array_%0d", k), {s_cen0, s_cen1, s_wen}, 6'b0);
      chk($sformatf("postrst_wrdy_%0d", k), s_rdy_w, 1);
    end
    step(1, 8'h15, 4'b0100, 0, 8'h0, 4'h1, '0);
    idle(4);
    chk("sb_drain", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
